// File: rtl/bp_pkg.sv
// Shared types and constants for the BTB/BHT branch predictor.
//   pd_type_t   : branch-resolution update type
//   btb_entry_t : one BTB entry (valid, tag, target, 2-bit direction counter)
//   ctr_train   : saturating 2-bit counter step
package bp_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned CTR_W     = 2;
    // Widest tag a 32-bit PC can produce; narrower tags are zero-extended
    // so the unused upper flops hold constant zero.
    localparam int unsigned TAG_MAX_W = 30;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        COND     = 2'b01,
        DIRECT   = 2'b10,
        INDIRECT = 2'b11
    } pd_type_t;

    localparam logic [CTR_W-1:0] CTR_SN = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WT = 2'b10;
    localparam logic [CTR_W-1:0] CTR_ST = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [PC_W-1:0]      target;
        logic [CTR_W-1:0]     ctr;
    } btb_entry_t;

    // Saturating counter: step up on taken, down on not taken.
    function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] ctr,
                                                   input logic             taken);
        logic [CTR_W-1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + CTR_W'(1);
        end else begin
            if (ctr != CTR_SN) res = ctr - CTR_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// BTB storage: flop array with two lookup read ports, one read port feeding
// the training read-modify-write, and one write port. Reads are asynchronous
// and see the pre-write contents during the write cycle. Only valid bits reset.
//   clk, rstn           : clock, async active-low reset
//   rd_idx_a_i/_b_i     : lookup indices;  rd_entry_a_c_o/_b_c_o : entries
//   rd_idx_u_i          : training index;  rd_entry_u_c_o       : entry
//   we_i, wr_idx_i, wr_entry_i : write port
module bp_btb
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx_a_i,
    output btb_entry_t       rd_entry_a_c_o,
    input  logic [IDX_W-1:0] rd_idx_b_i,
    output btb_entry_t       rd_entry_b_c_o,
    input  logic [IDX_W-1:0] rd_idx_u_i,
    output btb_entry_t       rd_entry_u_c_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  btb_entry_t       wr_entry_i
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]     valid_q;
    logic [TAG_MAX_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]      target_q [DEPTH];
    logic [CTR_W-1:0]     ctr_q    [DEPTH];

    // Valid bits: the only reset state in the table.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_entry_i.valid;
        end
    end

    // Payload: no reset, qualified by valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]    <= wr_entry_i.tag;
            target_q[wr_idx_i] <= wr_entry_i.target;
            ctr_q[wr_idx_i]    <= wr_entry_i.ctr;
        end
    end

    assign rd_entry_a_c_o = {valid_q[rd_idx_a_i], tag_q[rd_idx_a_i],
                             target_q[rd_idx_a_i], ctr_q[rd_idx_a_i]};
    assign rd_entry_b_c_o = {valid_q[rd_idx_b_i], tag_q[rd_idx_b_i],
                             target_q[rd_idx_b_i], ctr_q[rd_idx_b_i]};
    assign rd_entry_u_c_o = {valid_q[rd_idx_u_i], tag_q[rd_idx_u_i],
                             target_q[rd_idx_u_i], ctr_q[rd_idx_u_i]};

endmodule

// File: rtl/branch_predictor.sv
// Dual-slot BTB/BHT direction and target predictor.
// Looks up fetch-slot PCs A and B, registers a taken bit and next PC per slot
// (1-cycle latency), and trains from the single EX branch-resolution update.
//   clk, rstn                 : clock, async active-low reset
//   IF_valid/IF_stall/IF_flush: fetch control
//   IF_pc_a, IF_pc_b          : slot PCs (B = A+4)
//   IF_br_pd_a/_b, IF_pc_pd_a/_b : registered taken bits / predicted next PCs
//   IF_cut_b                  : slot B on wrong path (mirrors IF_br_pd_a)
//   IF_pd_valid               : prediction outputs meaningful
//   EX_upd_*                  : resolution update (type, pc, taken, target)
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        IF_valid,
    input  logic        IF_stall,
    input  logic        IF_flush,
    input  logic [31:0] IF_pc_a,
    input  logic [31:0] IF_pc_b,
    output logic        IF_br_pd_a,
    output logic        IF_br_pd_b,
    output logic [31:0] IF_pc_pd_a,
    output logic [31:0] IF_pc_pd_b,
    output logic        IF_cut_b,
    output logic        IF_pd_valid,
    input  logic        EX_upd_valid,
    input  logic [1:0]  EX_upd_type,
    input  logic [31:0] EX_upd_pc,
    input  logic        EX_upd_jump,
    input  logic [31:0] EX_upd_target
);

    localparam int unsigned IDX_LO = 2;
    localparam int unsigned IDX_HI = IDX_W + 1;
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    // ---------------- index / tag extraction ----------------
    logic [IDX_W-1:0]     idx_a, idx_b, idx_u;
    logic [TAG_MAX_W-1:0] tag_a, tag_b, tag_u;

    assign idx_a = IF_pc_a[IDX_HI:IDX_LO];
    assign idx_b = IF_pc_b[IDX_HI:IDX_LO];
    assign idx_u = EX_upd_pc[IDX_HI:IDX_LO];
    assign tag_a = TAG_MAX_W'(IF_pc_a[TAG_HI:TAG_LO]);
    assign tag_b = TAG_MAX_W'(IF_pc_b[TAG_HI:TAG_LO]);
    assign tag_u = TAG_MAX_W'(EX_upd_pc[TAG_HI:TAG_LO]);

    // Bits of the update PC outside index/tag are irrelevant to training.
    logic unused_upd_pc;
    assign unused_upd_pc = ^EX_upd_pc;

    // ---------------- table ----------------
    btb_entry_t rd_a, rd_b, rd_u, wr_entry;
    logic       we;

    bp_btb #(
        .IDX_W(IDX_W)
    ) u_btb (
        .clk            (clk),
        .rstn           (rstn),
        .rd_idx_a_i     (idx_a),
        .rd_entry_a_c_o (rd_a),
        .rd_idx_b_i     (idx_b),
        .rd_entry_b_c_o (rd_b),
        .rd_idx_u_i     (idx_u),
        .rd_entry_u_c_o (rd_u),
        .we_i           (we),
        .wr_idx_i       (idx_u),
        .wr_entry_i     (wr_entry)
    );

    // ---------------- lookup (pre-update state) ----------------
    logic        taken_a, taken_b;
    logic [31:0] npc_a, npc_b;

    always_comb begin
        taken_a = rd_a.valid && (rd_a.tag == tag_a) && rd_a.ctr[1];
        taken_b = rd_b.valid && (rd_b.tag == tag_b) && rd_b.ctr[1];
        npc_a   = taken_a ? rd_a.target : IF_pc_a + 32'd4;
        npc_b   = taken_b ? rd_b.target : IF_pc_b + 32'd4;
    end

    // ---------------- training ----------------
    pd_type_t upd_type;
    logic     upd_en, hit_u;

    assign upd_type = pd_type_t'(EX_upd_type);
    assign upd_en   = EX_upd_valid && (upd_type != NONE);
    assign hit_u    = rd_u.valid && (rd_u.tag == tag_u);

    // Read-modify-write of the update entry; a miss allocates only if taken.
    always_comb begin
        we             = 1'b0;
        wr_entry       = rd_u;
        wr_entry.valid = 1'b1;
        wr_entry.tag   = tag_u;
        if (upd_en) begin
            if (hit_u) begin
                unique case (upd_type)
                    COND: begin
                        we           = 1'b1;
                        wr_entry.ctr = ctr_train(rd_u.ctr, EX_upd_jump);
                        if (EX_upd_jump) wr_entry.target = EX_upd_target;
                    end
                    DIRECT, INDIRECT: begin
                        we              = 1'b1;
                        wr_entry.ctr    = CTR_ST;
                        wr_entry.target = EX_upd_target;
                    end
                    default: we = 1'b0;
                endcase
            end else if (EX_upd_jump) begin
                we              = 1'b1;
                wr_entry.target = EX_upd_target;
                wr_entry.ctr    = (upd_type == COND) ? CTR_WT : CTR_ST;
            end
        end
    end

    // ---------------- output registers ----------------
    logic        pd_valid_d, pd_valid_q;
    logic        br_pd_a_d,  br_pd_a_q;
    logic        br_pd_b_d,  br_pd_b_q;
    logic [31:0] pc_pd_a_d,  pc_pd_a_q;
    logic [31:0] pc_pd_b_d,  pc_pd_b_q;

    // Flush beats stall; flush leaves the predicted PCs untouched.
    always_comb begin
        pd_valid_d = pd_valid_q;
        br_pd_a_d  = br_pd_a_q;
        br_pd_b_d  = br_pd_b_q;
        pc_pd_a_d  = pc_pd_a_q;
        pc_pd_b_d  = pc_pd_b_q;
        if (IF_flush) begin
            pd_valid_d = 1'b0;
            br_pd_a_d  = 1'b0;
            br_pd_b_d  = 1'b0;
        end else if (!IF_stall) begin
            pd_valid_d = IF_valid;
            br_pd_a_d  = IF_valid && taken_a;
            br_pd_b_d  = IF_valid && taken_b;
            pc_pd_a_d  = npc_a;
            pc_pd_b_d  = npc_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pd_valid_q <= 1'b0;
            br_pd_a_q  <= 1'b0;
            br_pd_b_q  <= 1'b0;
            pc_pd_a_q  <= '0;
            pc_pd_b_q  <= '0;
        end else begin
            pd_valid_q <= pd_valid_d;
            br_pd_a_q  <= br_pd_a_d;
            br_pd_b_q  <= br_pd_b_d;
            pc_pd_a_q  <= pc_pd_a_d;
            pc_pd_b_q  <= pc_pd_b_d;
        end
    end

    assign IF_pd_valid = pd_valid_q;
    assign IF_br_pd_a  = br_pd_a_q;
    assign IF_br_pd_b  = br_pd_b_q;
    assign IF_pc_pd_a  = pc_pd_a_q;
    assign IF_pc_pd_b  = pc_pd_b_q;
    // Taken in slot A redirects fetch, so slot B is on the wrong path.
    assign IF_cut_b    = br_pd_a_q;

endmodule
